// File: rtl/num_stream_tx_pkg.sv
// Shared types and widths for the number-stream initiator.
// The compute block consumes 4-bit operands and a 2-bit mode, and returns a 6-bit signed result.
package num_stream_pkg;

  localparam int NUM_W  = 4;
  localparam int MODE_W = 2;
  localparam int RES_W  = 6;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    RESP
  } state_t;

  typedef logic signed [RES_W-1:0] result_t;

endpackage

// File: rtl/num_stream_tx_if.sv
// Bundles the job request/response port and the burst protocol toward the compute block.
// The master side is the initiator; the slave side is the requester plus the compute block.
interface num_stream_tx_if #(
  parameter int N = 8
);
  import num_stream_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [NUM_W*N-1:0]    req_numbers;
  logic [MODE_W-1:0]     req_mode;

  logic                  in_valid;
  logic [NUM_W-1:0]      in_number;
  logic [MODE_W-1:0]     mode;
  logic                  out_valid;
  result_t               out_result;

  logic                  rsp_valid;
  result_t               rsp_result;
  logic                  rsp_timeout;
  logic                  proto_err;

  modport master (
    input  req_valid, req_numbers, req_mode, out_valid, out_result,
    output req_ready, in_valid, in_number, mode, rsp_valid, rsp_result,
           rsp_timeout, proto_err
  );

  modport slave (
    output req_valid, req_numbers, req_mode, out_valid, out_result,
    input  req_ready, in_valid, in_number, mode, rsp_valid, rsp_result,
           rsp_timeout, proto_err
  );

endinterface

// File: rtl/num_stream_tx.sv
// Serialises one job of N operands as an in_valid burst, then waits (bounded) for the
// compute block's result and returns it as a one-cycle response. All outputs registered.
module num_stream_tx
  import num_stream_pkg::*;
#(
  parameter int N       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  num_stream_tx_if.master  bus
);

  localparam int IDX_W = $clog2(N + 1);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_W*N-1:0]   nums_q, nums_d;
  logic                 req_ready_q, req_ready_d;
  logic                 in_valid_q, in_valid_d;
  logic [NUM_W-1:0]     in_number_q, in_number_d;
  logic [MODE_W-1:0]    mode_q, mode_d;
  logic                 rsp_valid_q, rsp_valid_d;
  result_t              rsp_result_q, rsp_result_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic                 proto_err_q, proto_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      nums_q        <= '0;
      req_ready_q   <= 1'b1;
      in_valid_q    <= 1'b0;
      in_number_q   <= '0;
      mode_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      nums_q        <= nums_d;
      req_ready_q   <= req_ready_d;
      in_valid_q    <= in_valid_d;
      in_number_q   <= in_number_d;
      mode_q        <= mode_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
      proto_err_q   <= proto_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    nums_d        = nums_q;
    req_ready_d   = req_ready_q;
    in_valid_d    = in_valid_q;
    in_number_d   = in_number_q;
    mode_d        = mode_q;
    rsp_valid_d   = 1'b0;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    proto_err_d   = proto_err_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          // Element 0 goes out straight from the request; the rest are shifted out of nums_q.
          state_d     = SEND;
          req_ready_d = 1'b0;
          in_valid_d  = 1'b1;
          in_number_d = bus.req_numbers[NUM_W-1:0];
          mode_d      = bus.req_mode;
          nums_d      = bus.req_numbers >> NUM_W;
          idx_d       = IDX_W'(1);
        end
      end

      SEND: begin
        if (bus.out_valid) begin
          proto_err_d = 1'b1;
        end
        if (idx_q == IDX_W'(N)) begin
          state_d     = WAIT;
          in_valid_d  = 1'b0;
          in_number_d = '0;
          mode_d      = '0;
          cnt_d       = '0;
        end else begin
          in_number_d = nums_q[NUM_W-1:0];
          nums_d      = nums_q >> NUM_W;
          mode_d      = '0;
          idx_d       = idx_q + IDX_W'(1);
        end
      end

      WAIT: begin
        // A result on the last permitted cycle takes priority over the timeout.
        if (bus.out_valid) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_result_d  = bus.out_result;
          rsp_timeout_d = 1'b0;
        end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.in_valid    = in_valid_q;
  assign bus.in_number   = in_number_q;
  assign bus.mode        = mode_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.proto_err   = proto_err_q;

endmodule

// File: tb/tb_num_stream_tx.sv
// Directed bench for num_stream_tx: the bench plays requester and compute-block stub,
// driving and sampling on the falling clock edge.
module tb_num_stream_tx;
  import num_stream_pkg::*;

  localparam int N   = 8;
  localparam int TMO = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  num_stream_tx_if #(.N(N)) bus ();

  num_stream_tx #(.N(N), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a job in IDLE and step past the acceptance edge; returns on burst cycle 0.
  task automatic start_job(input logic [4*N-1:0] nums, input logic [1:0] md);
    bus.req_valid   = 1'b1;
    bus.req_numbers = nums;
    bus.req_mode    = md;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid   = 1'b0;
    bus.req_numbers = '0;
    bus.req_mode    = '0;
    bus.out_valid   = 1'b0;
    bus.out_result  = '0;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.req_ready, bus.in_valid, bus.in_number, bus.mode} !== {1'b1, 1'b0, 4'd0, 2'd0}) begin
      errors++;
      $display("FAIL reset_burst got rdy=%b iv=%b num=%h mode=%h want 1 0 0 0",
               bus.req_ready, bus.in_valid, bus.in_number, bus.mode);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_timeout, bus.proto_err} !== 9'd0) begin
      errors++;
      $display("FAIL reset_rsp got v=%b r=%0d t=%b pe=%b want all 0",
               bus.rsp_valid, bus.rsp_result, bus.rsp_timeout, bus.proto_err);
    end
    rst_n = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_basic();
    result_t exp_r = -5;
    start_job(32'h87654321, 2'd2);
    for (int k = 0; k < N; k++) begin
      if (k > 0) tick();
      checks++;
      if ({bus.req_ready, bus.in_valid, bus.in_number, bus.mode} !==
          {1'b0, 1'b1, 4'(k + 1), (k == 0) ? 2'd2 : 2'd0}) begin
        errors++;
        $display("FAIL basic_burst%0d got rdy=%b iv=%b num=%h mode=%h want 0 1 %h %h", k,
                 bus.req_ready, bus.in_valid, bus.in_number, bus.mode, k + 1, (k == 0) ? 2 : 0);
      end
    end
    tick();
    checks++;
    if ({bus.in_valid, bus.in_number, bus.mode} !== 7'd0) begin
      errors++;
      $display("FAIL basic_after_burst got iv=%b num=%h mode=%h want 0 0 0",
               bus.in_valid, bus.in_number, bus.mode);
    end
    tick();
    tick();
    bus.out_valid  = 1'b1;
    bus.out_result = exp_r;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_rsp got rsp_valid=%b want 0", bus.rsp_valid);
    end
    tick();
    bus.out_valid = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_timeout, bus.proto_err} !=={1'b1, exp_r, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_rsp got v=%b r=%0d t=%b pe=%b want 1 -5 0 0",
               bus.rsp_valid, bus.rsp_result, bus.rsp_timeout, bus.proto_err);
    end
    tick();
    checks++;
    if ({bus.rsp_valid, bus.req_ready, bus.rsp_result} !== {1'b0, 1'b1, exp_r}) begin
      errors++;
      $display("FAIL basic_hold got v=%b rdy=%b r=%0d want 0 1 -5",
               bus.rsp_valid, bus.req_ready, bus.rsp_result);
    end
    $display("job basic: result %0d timeout %0d", bus.rsp_result, bus.rsp_timeout);
  endtask

  task automatic test_timeout();
    int seen = 0;
    start_job(32'h11111111, 2'd1);
    repeat (N - 1) tick();
    for (int w = 1; w <= 150 && seen == 0; w++) begin
      tick();
      if (bus.rsp_valid === 1'b1) seen = w;
    end
    checks++;
    if (seen != TMO + 1) begin
      errors++;
      $display("FAIL timeout_latency got %0d cycles after burst want %0d", seen, TMO + 1);
    end
    checks++;
    if ({bus.rsp_result, bus.rsp_timeout} !== {6'd0, 1'b1}) begin
      errors++;
      $display("FAIL timeout_rsp got r=%0d t=%b want 0 1", bus.rsp_result, bus.rsp_timeout);
    end
    tick();
    checks++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_ready got rdy=%b v=%b want 1 0", bus.req_ready, bus.rsp_valid);
    end
    $display("job timeout: result %0d timeout %0d", bus.rsp_result, bus.rsp_timeout);
  endtask

  task automatic test_boundary();
    result_t exp_r = 31;
    start_job(32'h0F0F0F0F, 2'd0);
    repeat (N - 1) tick();
    repeat (TMO) tick();
    bus.out_valid  = 1'b1;
    bus.out_result = exp_r;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL boundary_early got rsp_valid=%b want 0", bus.rsp_valid);
    end
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_timeout} !== {1'b1, exp_r, 1'b0}) begin
      errors++;
      $display("FAIL boundary_rsp got v=%b r=%0d t=%b want 1 31 0",
               bus.rsp_valid, bus.rsp_result, bus.rsp_timeout);
    end
    tick();
    bus.out_valid = 1'b0;
    tick();
    checks++;
    if (bus.proto_err !== 1'b0) begin
      errors++;
      $display("FAIL boundary_tail_perr got proto_err=%b want 0", bus.proto_err);
    end
    $display("job boundary: result %0d timeout %0d", bus.rsp_result, bus.rsp_timeout);
  endtask

  task automatic test_proto_err();
    result_t exp_r = -32;
    result_t got   = '0;
    int      pulses = 0;
    start_job(32'hFEDCBA98, 2'd3);
    repeat (3) tick();
    bus.out_valid  = 1'b1;
    bus.out_result = 6'sd7;
    tick();
    bus.out_valid = 1'b0;
    checks++;
    if ({bus.proto_err, bus.in_valid, bus.in_number} !== {1'b1, 1'b1, 4'hC}) begin
      errors++;
      $display("FAIL perr_set got pe=%b iv=%b num=%h want 1 1 c",
               bus.proto_err, bus.in_valid, bus.in_number);
    end
    repeat (3) tick();
    tick();
    bus.out_valid  = 1'b1;
    bus.out_result = exp_r;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) bus.out_valid = 1'b0;
      if (bus.rsp_valid === 1'b1) begin
        pulses++;
        got = bus.rsp_result;
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL perr_pulses got %0d rsp pulses want 1", pulses);
    end
    checks++;
    if ({got, bus.proto_err} !== {exp_r, 1'b1}) begin
      errors++;
      $display("FAIL perr_rsp got r=%0d pe=%b want -32 1", got, bus.proto_err);
    end
    $display("job proto_err: result %0d proto_err %0d", got, bus.proto_err);
  endtask

  task automatic test_reset_mid();
    int      bad = 0;
    result_t exp_r = 9;
    start_job(32'h12345678, 2'd1);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_valid, bus.req_ready, bus.proto_err} !== 3'b010) begin
      errors++;
      $display("FAIL rstmid_async got iv=%b rdy=%b pe=%b want 0 1 0",
               bus.in_valid, bus.req_ready, bus.proto_err);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || bus.in_valid !== 1'b0 || bus.req_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstmid_quiet got %0d active cycles want 0", bad);
    end
    start_job(32'h24682468, 2'd0);
    checks++;
    if ({bus.in_valid, bus.in_number} !== {1'b1, 4'h8}) begin
      errors++;
      $display("FAIL rstmid_restart got iv=%b num=%h want 1 8", bus.in_valid, bus.in_number);
    end
    repeat (N - 1) tick();
    tick();
    bus.out_valid  = 1'b1;
    bus.out_result = exp_r;
    tick();
    bus.out_valid = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_timeout} !== {1'b1, exp_r, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_rsp got v=%b r=%0d t=%b want 1 9 0",
               bus.rsp_valid, bus.rsp_result, bus.rsp_timeout);
    end
    tick();
    $display("job after reset: result %0d timeout %0d", bus.rsp_result, bus.rsp_timeout);
  endtask

  task automatic test_back_to_back();
    result_t ra = 10;
    result_t rb = -3;
    bus.req_valid   = 1'b1;
    bus.req_numbers = 32'h13579BDF;
    bus.req_mode    = 2'd1;
    tick();
    bus.req_numbers = 32'h02468ACE;
    bus.req_mode    = 2'd3;
    checks++;
    if ({bus.in_valid, bus.in_number, bus.mode} !== {1'b1, 4'hF, 2'd1}) begin
      errors++;
      $display("FAIL b2b_first got iv=%b num=%h mode=%h want 1 f 1",
               bus.in_valid, bus.in_number, bus.mode);
    end
    repeat (N - 1) tick();
    tick();
    bus.out_valid  = 1'b1;
    bus.out_result = ra;
    tick();
    bus.out_valid = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.req_ready, bus.in_valid} !== {1'b1, ra, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_rsp_a got v=%b r=%0d rdy=%b iv=%b want 1 10 0 0",
               bus.rsp_valid, bus.rsp_result, bus.req_ready, bus.in_valid);
    end
    $display("job b2b A: result %0d", bus.rsp_result);
    tick();
    checks++;
    if ({bus.req_ready, bus.in_valid, bus.rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_gap got rdy=%b iv=%b v=%b want 1 0 0",
               bus.req_ready, bus.in_valid, bus.rsp_valid);
    end
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.in_valid, bus.in_number, bus.mode} !== {1'b1, 4'hE, 2'd3}) begin
      errors++;
      $display("FAIL b2b_second got iv=%b num=%h mode=%h want 1 e 3",
               bus.in_valid, bus.in_number, bus.mode);
    end
    repeat (N - 1) tick();
    tick();
    bus.out_valid  = 1'b1;
    bus.out_result = rb;
    tick();
    bus.out_valid = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_timeout} !== {1'b1, rb, 1'b0}) begin
      errors++;
      $display("FAIL b2b_rsp_b got v=%b r=%0d t=%b want 1 -3 0",
               bus.rsp_valid, bus.rsp_result, bus.rsp_timeout);
    end
    $display("job b2b B: result %0d", bus.rsp_result);
    tick();
    checks++;
    if ({bus.req_ready, bus.in_valid} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_end got rdy=%b iv=%b want 1 0", bus.req_ready, bus.in_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_boundary();
    test_proto_err();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/num_stream_tx.md
Name: num_stream_tx

Overview:
- Initiator side of the in_valid / in_number / mode / out_valid / out_result protocol used by the lab06 accumulation blocks.
- Accepts one parallel job: N 4-bit operands plus a 2-bit mode.
- Serialises the job onto the protocol as a burst, then waits for the downstream result with a timeout.
- Returns the captured result on a response port. Replaces a testbench pattern driver so the compute block can be exercised in-system.

Parameters:
- N, 8, operands per job (burst length in cycles); legal 1..16.
- TIMEOUT, 64, max cycles to wait for out_valid after the burst ends; legal 1..1023.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  job request present.
- req_ready  output  1  block can accept a job (high only in IDLE).
- req_numbers  input  4*N  operands; element i = bits [4i+3:4i], element 0 sent first.
- req_mode  input  2  mode for the job.
- in_valid  output  1  burst-valid toward the compute block.
- in_number  output  4  current operand.
- mode  output  2  job mode, driven on the first burst cycle only.
- out_valid  input  1  result valid from the compute block.
- out_result  input  6 signed  result from the compute block.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_result  output  6 signed  captured result; 0 on timeout.
- rsp_timeout  output  1  qualifies rsp_valid: 1 = no result arrived.
- proto_err  output  1  sticky: out_valid seen while in SEND.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; req_ready=1; in_valid=0; in_number=0; mode=0; rsp_valid=0; rsp_result=0; rsp_timeout=0; proto_err=0; counters=0.
- All outputs are registered. Reset asserted mid-job aborts the job immediately; no response is produced.
- FSM states: IDLE, SEND, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept when req_valid=1 at a rising edge: latch req_numbers and req_mode; go to SEND.
  - req_ready=0 from the next cycle.
- SEND:
  - Exactly N consecutive cycles with in_valid=1. No bubbles.
  - Cycle k (k=0..N-1) drives in_number = element k.
  - mode = latched mode on k=0 and 0 on k>=1.
  - First in_valid cycle is the cycle after acceptance (latency 1).
  - After cycle N-1: in_valid=0, in_number=0, mode=0; go to WAIT.
  - out_valid=1 in SEND sets proto_err and is otherwise ignored.
- WAIT:
  - Wait counter starts at 0 on the first WAIT cycle and increments each cycle.
  - out_valid=1 sampled at an edge: capture out_result, go to RESP with timeout flag 0. out_valid is checked before the counter, so out_valid on the final count wins over timeout.
  - Counter reaching TIMEOUT with no out_valid: go to RESP with result 0 and timeout flag 1.
- RESP:
  - Exactly one cycle: rsp_valid=1, with rsp_result and rsp_timeout as captured. Then go to IDLE.
  - rsp_result and rsp_timeout hold their values until the next response.
  - No back-pressure on the response port.
- out_valid handling: in WAIT only the first out_valid cycle is captured. out_valid in RESP or IDLE is ignored and does not set proto_err (multi-cycle out_valid tails are legal).
- req_valid outside IDLE is ignored; the requester must hold it until req_ready.
- Throughput: minimum job period N+3 cycles (accept, N sends, at least 1 WAIT, 1 RESP). The next acceptance can occur in the cycle after RESP.
- Counter widths: send index $clog2(N+1) bits; wait counter $clog2(TIMEOUT+1) bits. No wrap is possible.
- rsp_result is carried as signed with no extension or truncation.

Decomposition:
- Package num_stream_pkg:
  - state enum (IDLE, SEND, WAIT, RESP).
  - NUM_W=4, MODE_W=2, RES_W=6.
  - typedef logic signed [RES_W-1:0] result_t.
- No sub-module. The single FSM plus two counters is the natural size.
- lab06_4 can be instantiated beside this block in a loopback bench.

Test Plan:
1. Basic job: N=8, req_numbers = elements 1..8, req_mode=2; stub returns out_valid 3 cycles after the burst with out_result=-5 -> in_valid high exactly 8 cycles starting 1 cycle after acceptance; in_number sequence 1,2,...,8; mode=2 only on cycle 0; rsp_valid pulse 1 cycle with rsp_result=-5 and rsp_timeout=0.
2. Timeout: stub never asserts out_valid, TIMEOUT=64 -> rsp_valid with rsp_timeout=1 and rsp_result=0; the pulse occurs exactly 64 WAIT cycles plus 1 after the burst ends; req_ready returns to 1 on the next cycle.
3. Boundary: out_valid arrives on the cycle the wait counter hits TIMEOUT, out_result=31 -> rsp_result=31, rsp_timeout=0.
4. Protocol error: out_valid pulsed at SEND cycle 3, then a proper result -32 in WAIT -> proto_err=1 and stays 1; rsp_result=-32; holding out_valid for 3 cycles in WAIT produces exactly one rsp_valid.
5. Reset mid-burst: rst_n low at SEND cycle 4 -> in_valid drops asynchronously, no rsp_valid, req_ready=1 after release; a new job afterwards runs cleanly.
6. Back-to-back: req_valid held continuously with two different jobs -> second acceptance in the cycle after RESP; bursts separated by at least 2 idle in_valid cycles; responses returned in order.
